// File: rtl/cam_pkg.sv
// Shared DVP camera definitions: FSM state encoding, test-pattern encodings,
// and default frame timing constants (also used by the bridge bench).
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VS   = 3'd1,
    VBP  = 3'd2,
    LINE = 3'd3,
    HBL  = 3'd4,
    GAP  = 3'd5
  } dvp_state_e;

  localparam logic [1:0] PAT_INCR  = 2'd0;
  localparam logic [1:0] PAT_CONST = 2'd1;
  localparam logic [1:0] PAT_LINE  = 2'd2;
  localparam logic [1:0] PAT_ALT   = 2'd3;

  localparam int DEF_H_BYTES   = 128;
  localparam int DEF_V_LINES   = 8;
  localparam int DEF_VSYNC_LEN = 100;
  localparam int DEF_VS_BP     = 100;
  localparam int DEF_H_BLANK   = 10;
  localparam int DEF_FRAME_GAP = 1000;
  localparam int DEF_CNT_W     = 16;

  // Alternating pattern: 0x55 on even byte positions of a line, 0xAA on odd.
  function automatic logic [7:0] altByte(input logic oddByte);
    return oddByte ? 8'hAA : 8'h55;
  endfunction

endpackage

// File: rtl/dvp_pixel_src.sv
// Pixel byte source: picks the byte for the next href cycle from the
// frame's shadowed pattern selection, running byte count and line index.
module dvp_pixel_src
  import cam_pkg::*;
(
  input  logic [1:0] patSel,
  input  logic [7:0] constVal,
  input  logic [7:0] frameByte,
  input  logic [7:0] lineIdx,
  input  logic       oddByte,
  output logic [7:0] pixByte
);

  // Pattern multiplexer
  always_comb begin
    pixByte = frameByte;
    case (patSel)
      PAT_INCR:  pixByte = frameByte;
      PAT_CONST: pixByte = constVal;
      PAT_LINE:  pixByte = lineIdx;
      PAT_ALT:   pixByte = altByte(oddByte);
    endcase
  end

endmodule

// File: rtl/dvp_pattern_gen.sv
// DVP camera-sensor emulator. Generates vsync/href/data frames with
// programmable timing. All outputs are registered: the output process
// computes each output's next value from the next state and the state
// register process captures it, so pins never glitch on state decode.
// There are no handshakes; enable/pattern_sel/const_val are static levels,
// and the pattern inputs are only sampled when a frame starts.
module dvp_pattern_gen
  import cam_pkg::*;
#(
  parameter int H_BYTES   = DEF_H_BYTES,
  parameter int V_LINES   = DEF_V_LINES,
  parameter int VSYNC_LEN = DEF_VSYNC_LEN,
  parameter int VS_BP     = DEF_VS_BP,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int FRAME_GAP = DEF_FRAME_GAP,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic        pclk,
  input  logic        PReset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  const_val,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [2:0]  dbgState
);

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  if (CNT_W < 1 || CNT_W > 31) begin : gBadCntW
    $error("dvp_pattern_gen: CNT_W out of range");
  end
  if (H_BYTES < 1 || longint'(H_BYTES) > CNT_MAX) begin : gBadHBytes
    $error("dvp_pattern_gen: H_BYTES out of range");
  end
  if (V_LINES < 1 || longint'(V_LINES) > CNT_MAX) begin : gBadVLines
    $error("dvp_pattern_gen: V_LINES out of range");
  end
  if (VSYNC_LEN < 1 || longint'(VSYNC_LEN) > CNT_MAX) begin : gBadVsLen
    $error("dvp_pattern_gen: VSYNC_LEN out of range");
  end
  if (VS_BP < 1 || longint'(VS_BP) > CNT_MAX) begin : gBadVsBp
    $error("dvp_pattern_gen: VS_BP out of range");
  end
  if (H_BLANK < 1 || longint'(H_BLANK) > CNT_MAX) begin : gBadHBlank
    $error("dvp_pattern_gen: H_BLANK out of range");
  end
  if (FRAME_GAP < 1 || longint'(FRAME_GAP) > CNT_MAX) begin : gBadGap
    $error("dvp_pattern_gen: FRAME_GAP out of range");
  end

  // Terminal count for each timed state (state lasts LEN cycles, cnt 0..LEN-1)
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(VSYNC_LEN - 1);
  localparam logic [CNT_W-1:0] BP_LAST    = CNT_W'(VS_BP - 1);
  localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(H_BYTES - 1);
  localparam logic [CNT_W-1:0] HBL_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(FRAME_GAP - 1);
  localparam logic [CNT_W-1:0] LINES_LAST = CNT_W'(V_LINES - 1);

  dvp_state_e       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] lineIdx, lineNext;
  logic [7:0]       frameByte, frameByteNext;
  logic [1:0]       patShadow, patShadowNext;
  logic [7:0]       constShadow, constShadowNext;
  logic             vsyncNext, hrefNext, frameDoneNext, busyNext;
  logic [7:0]       pixByte;

  assign dbgState = state;

  // Next-state logic: each timed state exits when its cycle counter hits its last count
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (enable) stateNext = VS;
      VS:   if (cnt == VS_LAST) stateNext = VBP;
      VBP:  if (cnt == BP_LAST) stateNext = LINE;
      LINE: if (cnt == LINE_LAST) stateNext = HBL;
      HBL:  if (cnt == HBL_LAST) stateNext = (lineIdx == LINES_LAST) ? GAP : LINE;
      GAP:  if (cnt == GAP_LAST) stateNext = enable ? VS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output/datapath next values, all derived from the next state
  always_comb begin
    cntNext         = cnt + 1'b1;
    lineNext        = lineIdx;
    frameByteNext   = frameByte;
    patShadowNext   = patShadow;
    constShadowNext = constShadow;

    if (state == IDLE || stateNext != state) cntNext = '0;

    // Frame start: capture the pattern config and restart line/byte counts
    if (stateNext == VS && state != VS) begin
      patShadowNext   = pattern_sel;
      constShadowNext = const_val;
      lineNext        = '0;
      frameByteNext   = '0;
    end else if (state == HBL && stateNext == LINE) begin
      lineNext = lineIdx + 1'b1;
    end

    // frameByte indexes the byte about to be driven; it advances per href byte
    if (stateNext == LINE) frameByteNext = frameByte + 8'd1;

    vsyncNext     = (stateNext == VS);
    hrefNext      = (stateNext == LINE);
    busyNext      = (stateNext != IDLE);
    frameDoneNext = (stateNext == GAP) && (cntNext == GAP_LAST);
  end

  dvp_pixel_src uPixelSrc (
    .patSel    (patShadow),
    .constVal  (constShadow),
    .frameByte (frameByte),
    .lineIdx   (lineNext[7:0]),
    .oddByte   (cntNext[0]),
    .pixByte   (pixByte)
  );

  // State, counter, shadow and output registers; reset overrides everything
  always_ff @(posedge pclk) begin
    if (PReset) begin
      state       <= IDLE;
      cnt         <= '0;
      lineIdx     <= '0;
      frameByte   <= '0;
      patShadow   <= PAT_INCR;
      constShadow <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data        <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      lineIdx     <= lineNext;
      frameByte   <= frameByteNext;
      patShadow   <= patShadowNext;
      constShadow <= constShadowNext;
      vsync       <= vsyncNext;
      href        <= hrefNext;
      if (hrefNext) data <= pixByte;
      frame_done  <= frameDoneNext;
      busy        <= busyNext;
      if (frameDoneNext) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
